branch_recovery_ctrl: RTL and testbench

Sequences pipeline recovery after a branch misprediction. It sits beside the hazard/branch-prediction controller and watches branch resolution in the execute stage. On a mismatch it reloads the PC and PSW, squashes the younger fetch/decode contents for a fixed drain window, and gates the hazard-stall request while recovery is in progress. Optional counters record branch and misprediction totals for the debug/visualisation software.

---
 rtl/branch_recovery_ctrl.sv | 136 +++++++++++++
 tb/tb_branch_recovery_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/branch_recovery_ctrl.sv
// Branch misprediction recovery: redirect PC/PSW, flush fetch/decode, gate hazard stalls. Optional stats counters (BRANCH_RECOVERY_STATS_EN).
// Latency: pc_load one cycle after the mispredict edge; no backpressure, execute inputs are ignored while busy.
module branch_recovery_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  stall_in,
  input  logic        exec_valid,
  input  logic        exec_is_branch,
  input  logic        exec_pred_taken,
  input  logic        exec_actual_taken,
  input  logic [15:0] exec_target,
  input  logic [15:0] lbpc,
  input  logic [15:0] lbpsw,
  output logic        pc_load,
  output logic [15:0] pc_load_value,
  output logic        psw_restore,
  output logic [15:0] psw_value,
  output logic        flush_fetch,
  output logic        flush_decode,
  output logic        hold_fetch,
  output logic        busy,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count
);

  typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;

  localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] pcv_q, pcv_d;
  logic [15:0] pswv_q, pswv_d;
  logic        pc_load_q, pc_load_d;
  logic        flush_q, flush_d;
  logic        busy_q, busy_d;
  logic        accept_branch;
  logic        accept_mispredict;

  // Execute-stage results only count while idle; anything seen during recovery is wrong-path.
  assign accept_branch     = (state_q == IDLE) & exec_valid & exec_is_branch;
  assign accept_mispredict = accept_branch & (exec_pred_taken != exec_actual_taken);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcv_d   = pcv_q;
    pswv_d  = pswv_q;
    case (state_q)
      IDLE: begin
        if (accept_mispredict) begin
          state_d = REDIRECT;
          pcv_d   = exec_actual_taken ? exec_target : lbpc;
          pswv_d  = lbpsw;
        end
      end
      REDIRECT: begin
        cnt_d   = DRAIN_LOAD;
        state_d = DRAIN;
      end
      DRAIN: begin
        if (cnt_q == 3'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered, so decode them from the next state.
    pc_load_d = (state_d == REDIRECT);
    flush_d   = (state_d != IDLE);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      pcv_q     <= 16'h0000;
      pswv_q    <= 16'h0000;
      pc_load_q <= 1'b0;
      flush_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pcv_q     <= pcv_d;
      pswv_q    <= pswv_d;
      pc_load_q <= pc_load_d;
      flush_q   <= flush_d;
      busy_q    <= busy_d;
    end
  end

  assign pc_load       = pc_load_q;
  assign psw_restore   = pc_load_q;
  assign pc_load_value = pcv_q;
  assign psw_value     = pswv_q;
  assign flush_fetch   = flush_q;
  assign flush_decode  = flush_q;
  assign busy          = busy_q;
  // A stall during recovery is dropped: the dependent instruction is being squashed.
  assign hold_fetch    = (|stall_in) & (state_q == IDLE);

`ifdef BRANCH_RECOVERY_STATS_EN
  logic [15:0] branch_cnt_q, branch_cnt_d;
  logic [15:0] misp_cnt_q, misp_cnt_d;

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    misp_cnt_d   = misp_cnt_q;
    if (accept_branch && (branch_cnt_q != 16'hFFFF)) branch_cnt_d = branch_cnt_q + 16'd1;
    if (accept_mispredict && (misp_cnt_q != 16'hFFFF)) misp_cnt_d = misp_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q <= 16'h0000;
      misp_cnt_q   <= 16'h0000;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      misp_cnt_q   <= misp_cnt_d;
    end
  end

  assign branch_count     = branch_cnt_q;
  assign mispredict_count = misp_cnt_q;
`else
  assign branch_count     = 16'h0000;
  assign mispredict_count = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Directed bench for branch_recovery_ctrl: vector table plus multi-cycle recovery sequences.
module tb_branch_recovery_ctrl;

  localparam int DRAIN = 2;
`ifdef BRANCH_RECOVERY_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  stall_in;
  logic        exec_valid, exec_is_branch, exec_pred_taken, exec_actual_taken;
  logic [15:0] exec_target, lbpc, lbpsw;
  logic        pc_load, psw_restore, flush_fetch, flush_decode, hold_fetch, busy;
  logic [15:0] pc_load_value, psw_value, branch_count, mispredict_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_bc = 16'h0;
  logic [15:0] exp_mc = 16'h0;

  always #5 clk = ~clk;

  branch_recovery_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in),
    .exec_valid(exec_valid), .exec_is_branch(exec_is_branch),
    .exec_pred_taken(exec_pred_taken), .exec_actual_taken(exec_actual_taken),
    .exec_target(exec_target), .lbpc(lbpc), .lbpsw(lbpsw),
    .pc_load(pc_load), .pc_load_value(pc_load_value),
    .psw_restore(psw_restore), .psw_value(psw_value),
    .flush_fetch(flush_fetch), .flush_decode(flush_decode),
    .hold_fetch(hold_fetch), .busy(busy),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  typedef struct {
    logic        rst, ev, br, pt, at;
    logic [15:0] tgt, lpc, lpsw;
    logic [7:0]  stall;
    logic        e_ld;
    logic [15:0] e_pcv, e_pswv;
    logic        e_fl, e_hold, e_busy;
    logic [15:0] e_bc, e_mc;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic r, logic ev, logic br, logic pt, logic at,
                              logic [15:0] tgt, logic [15:0] lpc, logic [15:0] lpsw, logic [7:0] st,
                              logic ld, logic [15:0] pcv, logic [15:0] pswv,
                              logic fl, logic hold, logic bsy, logic [15:0] bc, logic [15:0] mc);
    vec_t v;
    v.rst = r; v.ev = ev; v.br = br; v.pt = pt; v.at = at;
    v.tgt = tgt; v.lpc = lpc; v.lpsw = lpsw; v.stall = st;
    v.e_ld = ld; v.e_pcv = pcv; v.e_pswv = pswv;
    v.e_fl = fl; v.e_hold = hold; v.e_busy = bsy; v.e_bc = bc; v.e_mc = mc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ld, input logic [15:0] pcv,
                         input logic [15:0] pswv, input logic fl, input logic hold,
                         input logic bsy, input logic [15:0] bc, input logic [15:0] mc);
    chk({tag, " pc_load"}, 16'(pc_load), 16'(ld));
    chk({tag, " psw_restore"}, 16'(psw_restore), 16'(ld));
    chk({tag, " pc_load_value"}, pc_load_value, pcv);
    chk({tag, " psw_value"}, psw_value, pswv);
    chk({tag, " flush_fetch"}, 16'(flush_fetch), 16'(fl));
    chk({tag, " flush_decode"}, 16'(flush_decode), 16'(fl));
    chk({tag, " hold_fetch"}, 16'(hold_fetch), 16'(hold));
    chk({tag, " busy"}, 16'(busy), 16'(bsy));
    chk({tag, " branch_count"}, branch_count, STATS ? bc : 16'h0);
    chk({tag, " mispredict_count"}, mispredict_count, STATS ? mc : 16'h0);
  endtask

  task automatic set_in(input logic r, input logic ev, input logic br, input logic pt, input logic at,
                        input logic [15:0] tgt, input logic [15:0] lpc, input logic [15:0] lpsw,
                        input logic [7:0] st);
    rst = r; exec_valid = ev; exec_is_branch = br; exec_pred_taken = pt; exec_actual_taken = at;
    exec_target = tgt; lbpc = lpc; lbpsw = lpsw; stall_in = st;
  endtask

  task automatic cycle;
    @(posedge clk);
    #1;
  endtask

  // One full recovery, mispredict driven on the current (idle) cycle; ends after the first new IDLE cycle.
  task automatic do_misp(input string tag, input logic taken, input logic [15:0] tgt,
                         input logic [15:0] lpc, input logic [15:0] lpsw);
    logic [15:0] pcv;
    pcv = taken ? tgt : lpc;
    @(negedge clk);
    set_in(1'b0, 1'b1, 1'b1, ~taken, taken, tgt, lpc, lpsw, 8'h00);
    if (exp_bc != 16'hFFFF) exp_bc++;
    if (exp_mc != 16'hFFFF) exp_mc++;
    cycle();
    chk_all({tag, " redirect"}, 1'b1, pcv, lpsw, 1'b1, 1'b0, 1'b1, exp_bc, exp_mc);
    for (int i = 0; i < DRAIN; i++) begin
      @(negedge clk);
      set_in(1'b0, 1'b1, 1'b1, taken, ~taken, ~tgt, ~lpc, ~lpsw, 8'h01);
      cycle();
      chk_all($sformatf("%s drain%0d", tag, i), 1'b0, pcv, lpsw, 1'b1, 1'b0, 1'b1, exp_bc, exp_mc);
    end
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 8'h00);
    cycle();
    chk_all({tag, " idle"}, 1'b0, pcv, lpsw, 1'b0, 1'b0, 1'b0, exp_bc, exp_mc);
  endtask

  initial begin
    vecs[0]  = mk(0,1,1,1,1,16'h3000,16'h0000,16'h0000,8'h00, 0,16'h0000,16'h0000,0,0,0,16'd1,16'd0);
    vecs[1]  = mk(0,1,1,1,0,16'h5555,16'h1006,16'hA5C3,8'h00, 1,16'h1006,16'hA5C3,1,0,1,16'd2,16'd1);
    vecs[2]  = mk(0,1,1,0,1,16'h7777,16'h1111,16'h2222,8'h04, 0,16'h1006,16'hA5C3,1,0,1,16'd2,16'd1);
    vecs[3]  = mk(0,1,1,0,1,16'h7777,16'h1111,16'h2222,8'h04, 0,16'h1006,16'hA5C3,1,0,1,16'd2,16'd1);
    vecs[4]  = mk(0,0,0,0,0,16'h0000,16'h0000,16'h0000,8'h04, 0,16'h1006,16'hA5C3,0,1,0,16'd2,16'd1);
    vecs[5]  = mk(1,1,1,1,0,16'h9999,16'h8888,16'h7777,8'h00, 0,16'h0000,16'h0000,0,0,0,16'd0,16'd0);
    vecs[6]  = mk(0,1,1,0,1,16'h2040,16'h1234,16'h0F0F,8'h00, 1,16'h2040,16'h0F0F,1,0,1,16'd1,16'd1);
    vecs[7]  = mk(0,0,0,0,0,16'h0000,16'h0000,16'h0000,8'h00, 0,16'h2040,16'h0F0F,1,0,1,16'd1,16'd1);
    vecs[8]  = mk(1,0,0,0,0,16'h0000,16'h0000,16'h0000,8'h00, 0,16'h0000,16'h0000,0,0,0,16'd0,16'd0);
    vecs[9]  = mk(0,0,0,0,0,16'h0000,16'h0000,16'h0000,8'h00, 0,16'h0000,16'h0000,0,0,0,16'd0,16'd0);
    vecs[10] = mk(0,1,0,0,1,16'h4444,16'h0005,16'h0006,8'h00, 0,16'h0000,16'h0000,0,0,0,16'd0,16'd0);
    vecs[11] = mk(0,0,1,0,1,16'h4444,16'h0005,16'h0006,8'h00, 0,16'h0000,16'h0000,0,0,0,16'd0,16'd0);
    vecs[12] = mk(0,1,1,0,0,16'h4444,16'h0005,16'h0006,8'h80, 0,16'h0000,16'h0000,0,1,0,16'd1,16'd0);

    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 8'h00);
    repeat (2) cycle();
    chk_all("reset", 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    chk_all("quiet", 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      set_in(vecs[i].rst, vecs[i].ev, vecs[i].br, vecs[i].pt, vecs[i].at,
             vecs[i].tgt, vecs[i].lpc, vecs[i].lpsw, vecs[i].stall);
      cycle();
      chk_all($sformatf("vec%0d", i), vecs[i].e_ld, vecs[i].e_pcv, vecs[i].e_pswv,
              vecs[i].e_fl, vecs[i].e_hold, vecs[i].e_busy, vecs[i].e_bc, vecs[i].e_mc);
    end

    // Five back-to-back recoveries, each starting on the first IDLE cycle after the last drain.
    exp_bc = 16'd1;
    exp_mc = 16'd0;
    do_misp("b2b0", 1'b1, 16'h2040, 16'h1002, 16'h0001);
    do_misp("b2b1", 1'b0, 16'h3000, 16'h1006, 16'h8002);
    do_misp("b2b2", 1'b1, 16'hFFFE, 16'h0000, 16'hFFFF);
    do_misp("b2b3", 1'b0, 16'h0000, 16'hABCD, 16'h1234);
    do_misp("b2b4", 1'b1, 16'h0100, 16'h0200, 16'h5A5A);

`ifdef BRANCH_RECOVERY_STATS_EN
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 8'h00);
    @(negedge clk);
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0, 8'h00);
    repeat (65540) @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 8'h00);
    cycle();
    exp_bc = 16'hFFFF;
    exp_mc = 16'h0000;
    chk_all("sat", 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, exp_bc, exp_mc);
    do_misp("satmisp", 1'b0, 16'h1111, 16'h2222, 16'h3333);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
